pls_receiver: RTL and testbench

Step-pulse receiver and decoder for one motor channel: the input-side counterpart of the per-axis step-pulse generator. It synchronises an external step/direction pair and counts steps into a signed position (up or down, with wrap). It measures the Clk-cycle period between steps and captures a home/reference position on a falling reference-switch edge. It sits between the board-level pulse/sensor pins and the motion-control register bank, and also serves as a loop-back checker for the pulse generator.

---
 rtl/pls_receiver.sv | 90 +++++++++
 tb/tb_pls_receiver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pls_receiver.sv
// pls_receiver: step/direction decoder with signed position count, reference capture and step-period timer
module pls_receiver #(
  parameter int CNT_W    = 16,
  parameter int PERIOD_W = 20
) (
  input  logic                Clk,
  input  logic                gRst,
  input  logic                Pls_In,
  input  logic                DirIn,
  input  logic                Ref,
  input  logic                RefEn,
  input  logic                RefClr,
  input  logic                PlsClr,
  output logic [CNT_W-1:0]    PlsCnt,
  output logic [CNT_W-1:0]    RefPos,
  output logic                RefDone,
  output logic [PERIOD_W-1:0] Period,
  output logic                PeriodValid,
  output logic                Stalled
);
  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;
  state_t              st_q;
  logic [2:0]          pls_q, ref_q;
  logic [1:0]          dir_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d, rpos_q, rpos_d;
  logic                rdone_q, rdone_d;
  logic [PERIOD_W-1:0] tmr_q, per_q;
  logic                pv_q, stl_q;
  logic                stp, cap;
  assign stp = pls_q[1] & ~pls_q[2];
  // a clear arriving with the reference edge suppresses the capture entirely
  assign cap = ~ref_q[1] & ref_q[2] & RefEn & ~rdone_q & ~RefClr;
  always_comb begin
    cnt_d   = (PlsClr | cap) ? '0 : stp ? (dir_q[1] ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1)) : cnt_q;
    rpos_d  = cap ? cnt_q : rpos_q;
    rdone_d = RefClr ? 1'b0 : (cap | rdone_q);
  end
  always_ff @(posedge Clk or posedge gRst) begin
    if (gRst) begin
      pls_q   <= '0;
      ref_q   <= '0;
      dir_q   <= '0;
      cnt_q   <= '0;
      rpos_q  <= '0;
      rdone_q <= 1'b0;
    end else begin
      pls_q   <= {pls_q[1:0], Pls_In};
      ref_q   <= {ref_q[1:0], Ref};
      dir_q   <= {dir_q[0], DirIn};
      cnt_q   <= cnt_d;
      rpos_q  <= rpos_d;
      rdone_q <= rdone_d;
    end
  end
  // the first step after IDLE or STALL only starts the timer; it has no interval
  always_ff @(posedge Clk or posedge gRst) begin
    if (gRst) begin
      st_q  <= IDLE;
      tmr_q <= '0;
      per_q <= '0;
      pv_q  <= 1'b0;
      stl_q <= 1'b1;
    end else begin
      pv_q <= 1'b0;
      if (stp) begin
        tmr_q <= PERIOD_W'(1);
        st_q  <= RUN;
        stl_q <= 1'b0;
        if (st_q == RUN) begin
          per_q <= tmr_q;
          pv_q  <= 1'b1;
        end
      end else if (st_q == RUN) begin
        if (&tmr_q) begin
          per_q <= '1;
          st_q  <= STALL;
          stl_q <= 1'b1;
        end else begin
          tmr_q <= tmr_q + PERIOD_W'(1);
        end
      end
    end
  end
  assign PlsCnt      = cnt_q;
  assign RefPos      = rpos_q;
  assign RefDone     = rdone_q;
  assign Period      = per_q;
  assign PeriodValid = pv_q;
  assign Stalled     = stl_q;
endmodule

// File: tb/tb_pls_receiver.sv
// tb_pls_receiver: drives two receivers (20-bit and 8-bit period) against a pin-sample-history model
module tb_pls_receiver;
  logic Clk = 0;
  logic gRst = 1;
  logic Pls_In = 0, DirIn = 0, Ref = 1, RefEn = 0, RefClr = 0, PlsClr = 0;
  logic [15:0] cnt_a, rpos_a, cnt_b, rpos_b;
  logic        done_a, done_b, pv_a, pv_b, stl_a, stl_b;
  logic [19:0] per_a;
  logic [7:0]  per_b;

  pls_receiver #(.CNT_W(16), .PERIOD_W(20)) dut (
    .Clk(Clk), .gRst(gRst), .Pls_In(Pls_In), .DirIn(DirIn), .Ref(Ref), .RefEn(RefEn),
    .RefClr(RefClr), .PlsClr(PlsClr), .PlsCnt(cnt_a), .RefPos(rpos_a), .RefDone(done_a),
    .Period(per_a), .PeriodValid(pv_a), .Stalled(stl_a));
  pls_receiver #(.CNT_W(16), .PERIOD_W(8)) dut8 (
    .Clk(Clk), .gRst(gRst), .Pls_In(Pls_In), .DirIn(DirIn), .Ref(Ref), .RefEn(RefEn),
    .RefClr(RefClr), .PlsClr(PlsClr), .PlsCnt(cnt_b), .RefPos(rpos_b), .RefDone(done_b),
    .Period(per_b), .PeriodValid(pv_b), .Stalled(stl_b));

  always #5 Clk = ~Clk;

  int total = 0, bad = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // pin samples taken at each clock edge since the last reset
  bit ph [0:65535];
  bit dh [0:65535];
  bit rh [0:65535];
  int n = 0, base = 0;
  int m_cnt = 0, m_rpos = 0;
  bit m_done = 0;
  int m_per [2] = '{0, 0};
  int m_tl  [2] = '{0, 0};
  bit m_pv  [2] = '{0, 0};
  bit m_run [2] = '{0, 0};
  int maxv  [2] = '{(1 << 20) - 1, 255};
  bit e_stp, e_ref, e_cap;

  function automatic bit smp(input int w, input int k);
    if (k < base) return 1'b0;
    return (w == 0) ? ph[k] : (w == 1) ? dh[k] : rh[k];
  endfunction

  // a pin level sampled at edge j affects outputs at edge j+2
  always @(posedge Clk or posedge gRst) begin
    if (gRst) begin
      base = n;
      m_cnt = 0; m_rpos = 0; m_done = 0;
      for (int w = 0; w < 2; w++) begin
        m_per[w] = 0; m_tl[w] = 0; m_pv[w] = 0; m_run[w] = 0;
      end
    end else begin
      ph[n] = Pls_In; dh[n] = DirIn; rh[n] = Ref;
      e_stp = smp(0, n - 2) && !smp(0, n - 3);
      e_ref = !smp(2, n - 2) && smp(2, n - 3);
      e_cap = e_ref && RefEn && !m_done && !RefClr;
      if (e_cap) m_rpos = m_cnt;
      if (PlsClr || e_cap) m_cnt = 0;
      else if (e_stp) m_cnt = (m_cnt + (smp(1, n - 2) ? 1 : 65535)) % 65536;
      m_done = RefClr ? 1'b0 : (e_cap || m_done);
      for (int w = 0; w < 2; w++) begin
        m_pv[w] = 0;
        if (e_stp) begin
          if (m_run[w]) begin
            m_per[w] = n - m_tl[w];
            m_pv[w] = 1;
          end
          m_tl[w] = n;
          m_run[w] = 1;
        end else if (m_run[w] && (n - m_tl[w] == maxv[w])) begin
          m_per[w] = maxv[w];
          m_run[w] = 0;
        end
      end
      n++;
    end
  end

  int pva = 0, pvb = 0;
  always @(negedge Clk) begin
    pva += int'(pv_a);
    pvb += int'(pv_b);
    chk("cnt_a", cnt_a, m_cnt);
    chk("rpos_a", rpos_a, m_rpos);
    chk("done_a", done_a, m_done);
    chk("per_a", per_a, m_per[0]);
    chk("pv_a", pv_a, m_pv[0]);
    chk("stl_a", stl_a, !m_run[0]);
    chk("cnt_b", cnt_b, m_cnt);
    chk("rpos_b", rpos_b, m_rpos);
    chk("done_b", done_b, m_done);
    chk("per_b", per_b, m_per[1]);
    chk("pv_b", pv_b, m_pv[1]);
    chk("stl_b", stl_b, !m_run[1]);
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge Clk);
  endtask
  task automatic pulse(input int hi, input int lo);
    Pls_In = 1; cyc(hi);
    Pls_In = 0; cyc(lo);
  endtask

  int pv0, c0;
  initial begin
    cyc(2);
    gRst = 0;
    chk("rst_stl", stl_a, 1);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_per", per_a, 0);
    chk("rst_done", done_a, 0);
    DirIn = 1; cyc(3);
    pulse(5, 5);
    chk("first_stl", stl_a, 0);
    chk("first_pv", pva, 0);
    repeat (4) pulse(5, 5);
    chk("five_cnt", cnt_a, 5);
    chk("five_per", per_a, 10);
    chk("five_pv", pva, 4);
    chk("five_per8", per_b, 10);
    PlsClr = 1; cyc(1); PlsClr = 0;
    DirIn = 0; cyc(3);
    pulse(3, 3);
    chk("wrap_dn", cnt_a, 16'hFFFF);
    DirIn = 1; cyc(3);
    pulse(3, 3);
    chk("wrap_up", cnt_a, 0);
    repeat (37) pulse(2, 2);
    chk("cnt37", cnt_a, 37);
    RefEn = 1; Ref = 0; cyc(5);
    chk("ref_pos", rpos_a, 37);
    chk("ref_cnt", cnt_a, 0);
    chk("ref_done", done_a, 1);
    Ref = 1; cyc(4);
    repeat (3) pulse(2, 2);
    Ref = 0; cyc(5);
    chk("ref2_pos", rpos_a, 37);
    chk("ref2_cnt", cnt_a, 3);
    Ref = 1; RefClr = 1; cyc(1); RefClr = 0;
    chk("refclr", done_a, 0);
    cyc(4);
    Pls_In = 1; Ref = 0; cyc(4);
    chk("coinc_cnt", cnt_a, 0);
    chk("coinc_pos", rpos_a, 3);
    Pls_In = 0; Ref = 1; RefClr = 1; cyc(1); RefClr = 0; cyc(3);
    repeat (2) pulse(2, 2);
    Pls_In = 1; cyc(2);
    PlsClr = 1; cyc(1); PlsClr = 0;
    Pls_In = 0; cyc(3);
    chk("clr_stp", cnt_a, 0);
    pulse(2, 2);
    pv0 = pvb;
    cyc(300);
    chk("stall8", stl_b, 1);
    chk("stall8_per", per_b, 8'hFF);
    chk("stall8_pv", pvb, pv0);
    pulse(10, 10);
    chk("restart8_per", per_b, 8'hFF);
    pulse(10, 10);
    chk("restart8_per2", per_b, 20);
    chk("restart8_pv", pvb, pv0 + 1);
    c0 = int'(cnt_a);
    repeat (6) pulse(1024, 1024);
    chk("loop_per", per_a, 2048);
    chk("loop_cnt", cnt_a, (c0 + 6) % 65536);
    c0 = int'(cnt_a);
    Pls_In = 1; cyc(1); Pls_In = 0; cyc(5);
    chk("glitch", ((int'(cnt_a) - c0 + 65536) % 65536) <= 1, 1);
    repeat (3000) begin
      if ($urandom_range(3) == 0) Pls_In = ~Pls_In;
      if ($urandom_range(15) == 0) DirIn = ~DirIn;
      if ($urandom_range(7) == 0) Ref = ~Ref;
      if ($urandom_range(7) == 0) RefEn = $urandom_range(1) == 1;
      RefClr = $urandom_range(19) == 0;
      PlsClr = $urandom_range(39) == 0;
      cyc(1);
    end
    RefClr = 0; PlsClr = 0;
    DirIn = 1; cyc(3);
    repeat (3) pulse(3, 3);
    Pls_In = 1; cyc(1);
    #2 gRst = 1;
    #1;
    chk("arst_cnt", cnt_a, 0);
    chk("arst_pos", rpos_a, 0);
    chk("arst_done", done_a, 0);
    chk("arst_per", per_a, 0);
    chk("arst_stl", stl_a, 1);
    @(negedge Clk);
    gRst = 0; Pls_In = 0; cyc(3);
    pulse(3, 3);
    chk("post_rst_cnt", cnt_a, 1);
    cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
